ram_seq: RTL and testbench

Access sequencer for the 64 KB RAM array. It accepts one read or write request at a time over a valid/ready handshake and registers the address and data. It holds them stable for a fixed number of settling cycles while the demux decode and mux read trees resolve. It then pulses the array's load line for a write, or captures the mux output for a read. The array is built from `dfrl` cells behind `demux8` decode and `mux8` read trees; this block is the single sequential front end that drives it.

---
 rtl/ram_pkg.sv | 16 +
 rtl/ram_wait_cnt.sv | 34 +++
 rtl/ram_seq.sv | 151 +++++++++++++++
 tb/tb_ram_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared widths and FSM state type for the RAM access sequencer
package ram_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WR,
    ST_RD,
    ST_RSP
  } ram_seq_state_t;

endpackage

// File: rtl/ram_wait_cnt.sv
// rtl/ram_wait_cnt.sv - loadable settling-cycle down-counter with zero flag
module ram_wait_cnt
  import ram_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ram_seq.sv
// rtl/ram_seq.sv - single-request sequencer driving the RAM array decode/mux trees
// Optional even-parity protection on the array data path: RAM_SEQ_PARITY_EN.
module ram_seq #(
  parameter int          ADDR_W      = ram_pkg::ADDR_W,
  parameter int          DATA_W      = ram_pkg::DATA_W,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
`ifdef RAM_SEQ_PARITY_EN
  output logic [DATA_W:0]   mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W:0]   mem_rdata,
  output logic              busy,
  output logic              rsp_err
`else
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`endif
);

  import ram_pkg::*;

`ifdef RAM_SEQ_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  ram_seq_state_t    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [MW-1:0]     wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              cnt_load, cnt_dec, cnt_zero;

  ram_wait_cnt u_wait_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (cnt_load),
    .load_val_i (WAIT_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
`ifdef RAM_SEQ_PARITY_EN
          wdata_d  = {^req_wdata, req_wdata};
`else
          wdata_d  = req_wdata;
`endif
          we_d     = req_we;
          cnt_load = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = req_we ? ST_WR : ST_RD;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          state_d = we_q ? ST_WR : ST_RD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WR: begin
        state_d = ST_IDLE;
      end
      ST_RD: begin
        rdata_d = mem_rdata[DATA_W-1:0];
`ifdef RAM_SEQ_PARITY_EN
        err_d   = ^mem_rdata;
`else
        err_d   = 1'b0;
`endif
        state_d = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Gate ready with reset so upstream never sees an accept window while held in reset.
  assign req_ready = reset && (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign mem_we    = (state_q == ST_WR);
  assign rsp_valid = (state_q == ST_RSP);
  assign rsp_rdata = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
`ifdef RAM_SEQ_PARITY_EN
  assign rsp_err   = err_q;
`endif

  logic unused_err;
  assign unused_err = err_q;

endmodule

// File: tb/tb_ram_seq.sv
// tb/tb_ram_seq.sv - directed self-checking bench for ram_seq (W=1 and W=0 instances)
module tb_ram_seq;

`ifdef RAM_SEQ_PARITY_EN
  localparam int MW = 9;
`else
  localparam int MW = 8;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          r1_valid, r1_we, rdy1, rv1, rr1, we1, busy1, flip1;
  logic [15:0]   r1_addr, ma1;
  logic [7:0]    r1_wdata, rd1;
  logic [MW-1:0] mw1, mr1;
  logic          r0_valid, r0_we, rdy0, rv0, rr0, we0, busy0;
  logic [15:0]   r0_addr, ma0;
  logic [7:0]    r0_wdata, rd0;
  logic [MW-1:0] mw0, mr0;
`ifdef RAM_SEQ_PARITY_EN
  logic          err1, err0;
`endif

  logic [MW-1:0] mem1 [0:65535];
  int            we_cnt = 0;
  int            n_tests = 0;
  int            n_fail = 0;

  always @(posedge clk) begin
    if (we1) begin
      mem1[ma1] <= mw1;
      we_cnt    <= we_cnt + 1;
    end
  end
  assign mr1 = mem1[ma1] ^ MW'(flip1);
  assign mr0 = MW'(8'h66);

  ram_seq #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(r1_valid), .req_ready(rdy1), .req_we(r1_we),
    .req_addr(r1_addr), .req_wdata(r1_wdata), .rsp_valid(rv1), .rsp_ready(rr1),
    .rsp_rdata(rd1), .mem_addr(ma1), .mem_wdata(mw1), .mem_we(we1), .mem_rdata(mr1),
`ifdef RAM_SEQ_PARITY_EN
    .busy(busy1), .rsp_err(err1)
`else
    .busy(busy1)
`endif
  );

  ram_seq #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(r0_valid), .req_ready(rdy0), .req_we(r0_we),
    .req_addr(r0_addr), .req_wdata(r0_wdata), .rsp_valid(rv0), .rsp_ready(rr0),
    .rsp_rdata(rd0), .mem_addr(ma0), .mem_wdata(mw0), .mem_we(we0), .mem_rdata(mr0),
`ifdef RAM_SEQ_PARITY_EN
    .busy(busy0), .rsp_err(err0)
`else
    .busy(busy0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] enc(input logic [7:0] d);
`ifdef RAM_SEQ_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  task automatic wr1(input logic [15:0] a, input logic [7:0] d);
    chk("wr_pre_ready", 32'(rdy1), 32'(1));
    r1_valid = 1'b1; r1_we = 1'b1; r1_addr = a; r1_wdata = d;
    @(negedge clk);
    chk("wr_wait_we", 32'(we1), 32'(0));
    chk("wr_wait_ready", 32'(rdy1), 32'(0));
    r1_valid = 1'b0;
    @(negedge clk);
    chk("wr_we", 32'(we1), 32'(1));
    chk("wr_addr", 32'(ma1), 32'(a));
    chk("wr_data", 32'(mw1), 32'(enc(d)));
    @(negedge clk);
    chk("wr_we_drop", 32'(we1), 32'(0));
    chk("wr_ready_back", 32'(rdy1), 32'(1));
  endtask

  task automatic rd1t(input logic [15:0] a, input logic [7:0] exp_d, input logic exp_err);
    r1_valid = 1'b1; r1_we = 1'b0; r1_addr = a;
    @(negedge clk);
    chk("rd_wait_valid", 32'(rv1), 32'(0));
    r1_valid = 1'b0;
    @(negedge clk);
    chk("rd_rd_valid", 32'(rv1), 32'(0));
    chk("rd_rd_busy", 32'(busy1), 32'(1));
    @(negedge clk);
    chk("rd_rsp_valid", 32'(rv1), 32'(1));
    chk("rd_rsp_data", 32'(rd1), 32'(exp_d));
`ifdef RAM_SEQ_PARITY_EN
    chk("rd_rsp_err", 32'(err1), 32'(exp_err));
`else
    chk("rd_no_err", 32'(exp_err), 32'(0));
`endif
    @(negedge clk);
    chk("rd_valid_drop", 32'(rv1), 32'(0));
    chk("rd_ready_back", 32'(rdy1), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; flip1 = 1'b0;
    r1_valid = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0; rr1 = 1'b1;
    r0_valid = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0; rr0 = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_ready_low", 32'(rdy1), 32'(0));
    chk("rst_busy", 32'(busy1), 32'(0));
    chk("rst_we", 32'(we1), 32'(0));
    chk("rst_rsp_valid", 32'(rv1), 32'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(rdy1), 32'(1));
    chk("rst_addr", 32'(ma1), 32'(16'h0000));
    chk("rst_wdata", 32'(mw1), 32'(0));
    chk("rst_rdata", 32'(rd1), 32'(0));
    chk("rst_ready0", 32'(rdy0), 32'(1));

    wr1(16'h1234, 8'hA5);
    chk("wr_a5_encoded", 32'(mw1), 32'(9'h0A5));
    rd1t(16'h1234, 8'hA5, 1'b0);
    chk("addr_hold_idle", 32'(ma1), 32'(16'h1234));

    wr1(16'hFFFF, 8'h5A);
    rr1 = 1'b0;
    r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 16'hFFFF;
    @(negedge clk);
    r1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rv1), 32'(1));
      chk("bp_data", 32'(rd1), 32'(8'h5A));
      chk("bp_ready", 32'(rdy1), 32'(0));
      chk("bp_addr", 32'(ma1), 32'(16'hFFFF));
      r1_valid = 1'b1; r1_we = 1'b1; r1_addr = 16'h0001; r1_wdata = 8'hEE;
      @(negedge clk);
    end
    chk("bp_no_accept_we", 32'(we1), 32'(0));
    r1_valid = 1'b0;
    rr1 = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(rv1), 32'(0));
    chk("bp_release_ready", 32'(rdy1), 32'(1));
    chk("bp_release_addr", 32'(ma1), 32'(16'hFFFF));

    r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 16'h0000; r0_wdata = 8'h11;
    @(negedge clk);
    chk("w0_we", 32'(we0), 32'(1));
    chk("w0_addr", 32'(ma0), 32'(16'h0000));
    chk("w0_data", 32'(mw0), 32'(8'h11));
    chk("w0_ready_low", 32'(rdy0), 32'(0));
    r0_valid = 1'b0;
    @(negedge clk);
    chk("w0_we_drop", 32'(we0), 32'(0));
    chk("w0_ready", 32'(rdy0), 32'(1));
    r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 16'h8000;
    @(negedge clk);
    chk("w0_rd_busy", 32'(busy0), 32'(1));
    chk("w0_rd_valid", 32'(rv0), 32'(0));
    r0_valid = 1'b0;
    @(negedge clk);
    chk("w0_rsp_valid", 32'(rv0), 32'(1));
    chk("w0_rsp_data", 32'(rd0), 32'(8'h66));
    @(negedge clk);
    chk("w0_rsp_done", 32'(rdy0), 32'(1));

    begin
      int we_base;
      we_base = we_cnt;
      r1_valid = 1'b1; r1_we = 1'b1; r1_addr = 16'h00FF; r1_wdata = 8'h77;
      @(negedge clk);
      chk("mid_wait_busy", 32'(busy1), 32'(1));
      r1_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("mid_we", 32'(we1), 32'(0));
      chk("mid_busy", 32'(busy1), 32'(0));
      chk("mid_ready", 32'(rdy1), 32'(0));
      chk("mid_rsp_valid", 32'(rv1), 32'(0));
      chk("mid_addr", 32'(ma1), 32'(0));
      chk("mid_wdata", 32'(mw1), 32'(0));
      chk("mid_rdata", 32'(rd1), 32'(0));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_ready_back", 32'(rdy1), 32'(1));
      chk("mid_we_never", 32'(we_cnt - we_base), 32'(0));
    end

`ifdef RAM_SEQ_PARITY_EN
    wr1(16'h0042, 8'h07);
    chk("par_stored", 32'(mem1[16'h0042]), 32'(9'h107));
    flip1 = 1'b1;
    rd1t(16'h0042, 8'h06, 1'b1);
    flip1 = 1'b0;
    rd1t(16'h0042, 8'h07, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
